// File: rtl/window_pos_gen.sv
// Window position generator: for each scale command, walks every legal window origin
// in raster order and emits one (x, y, scale) beat per window over valid/ready.
module window_pos_gen #(
  parameter int unsigned IMG_WIDTH  = 45,
  parameter int unsigned IMG_HEIGHT = 45,
  parameter int unsigned WIN_SIZE   = 24,
  parameter int unsigned X_STEP     = 1,
  parameter int unsigned Y_STEP     = 1,
  localparam int unsigned W_X = $clog2(IMG_WIDTH),
  localparam int unsigned W_Y = $clog2(IMG_HEIGHT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [7:0]     cmd_scale,
  input  logic [W_X:0]   cmd_width,
  input  logic [W_Y:0]   cmd_height,
  input  logic           cmd_last,
  output logic           window_pos_valid,
  input  logic           window_pos_ready,
  output logic           window_pos_eot,
  output logic [7:0]     window_pos_scale,
  output logic [W_X-1:0] window_pos_x,
  output logic [W_Y-1:0] window_pos_y,
  output logic           busy
);

  localparam logic [W_X:0] XStepW = (W_X + 1)'(X_STEP);
  localparam logic [W_Y:0] YStepW = (W_Y + 1)'(Y_STEP);
  localparam logic [W_X:0] WinW   = (W_X + 1)'(WIN_SIZE);
  localparam logic [W_Y:0] WinH   = (W_Y + 1)'(WIN_SIZE);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e         state_q, state_d;
  logic [W_X-1:0] x_q, x_d;
  logic [W_Y-1:0] y_q, y_d;
  logic [W_X:0]   x_max_q, x_max_d;
  logic [W_Y:0]   y_max_q, y_max_d;
  logic [7:0]     scale_q, scale_d;
  logic           last_q, last_d;

  logic [W_X:0]   x_sum;
  logic [W_Y:0]   y_sum;
  logic           last_x, last_y;
  logic           degenerate;

  // Sums are one bit wider than the coordinates so the end-of-row test never wraps.
  assign x_sum      = {1'b0, x_q} + XStepW;
  assign y_sum      = {1'b0, y_q} + YStepW;
  assign last_x     = (x_sum > x_max_q);
  assign last_y     = (y_sum > y_max_q);
  assign degenerate = (cmd_width < WinW) || (cmd_height < WinH);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x_max_d = x_max_q;
    y_max_d = y_max_q;
    scale_d = scale_q;
    last_d  = last_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          scale_d = cmd_scale;
          last_d  = cmd_last;
          x_d     = '0;
          y_d     = '0;
          if (degenerate) begin
            // A too-small last scale still yields one (0,0) beat so the frame gets its eot.
            x_max_d = '0;
            y_max_d = '0;
            if (cmd_last) begin
              state_d = StScan;
            end
          end else begin
            x_max_d = cmd_width - WinW;
            y_max_d = cmd_height - WinH;
            state_d = StScan;
          end
        end
      end
      StScan: begin
        if (window_pos_ready) begin
          if (!last_x) begin
            x_d = x_sum[W_X-1:0];
          end else if (!last_y) begin
            x_d = '0;
            y_d = y_sum[W_Y-1:0];
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      x_max_q <= '0;
      y_max_q <= '0;
      scale_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x_max_q <= x_max_d;
      y_max_q <= y_max_d;
      scale_q <= scale_d;
      last_q  <= last_d;
    end
  end

  assign cmd_ready        = (state_q == StIdle);
  assign window_pos_valid = (state_q == StScan);
  assign busy             = (state_q == StScan);
  assign window_pos_eot   = (state_q == StScan) & last_q & last_x & last_y;
  assign window_pos_scale = scale_q;
  assign window_pos_x     = x_q;
  assign window_pos_y     = y_q;

endmodule

// File: tb/tb_window_pos_gen.sv
// Bench for window_pos_gen: unit-stride and stride-4 instances checked beat by beat
// against a raster-order list of expected window origins.
module tb_window_pos_gen;

  localparam int WIN = 24;

  logic       clk;
  logic       rst;
  logic       cmd_valid  [2];
  logic       cmd_ready  [2];
  logic [7:0] cmd_scale  [2];
  logic [6:0] cmd_width  [2];
  logic [6:0] cmd_height [2];
  logic       cmd_last   [2];
  logic       pos_valid  [2];
  logic       pos_ready  [2];
  logic       pos_eot    [2];
  logic [7:0] pos_scale  [2];
  logic [5:0] pos_x      [2];
  logic [5:0] pos_y      [2];
  logic       busy       [2];

  int vectors;
  int miscompares;

  window_pos_gen u_dut0 (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid[0]),
    .cmd_ready        (cmd_ready[0]),
    .cmd_scale        (cmd_scale[0]),
    .cmd_width        (cmd_width[0]),
    .cmd_height       (cmd_height[0]),
    .cmd_last         (cmd_last[0]),
    .window_pos_valid (pos_valid[0]),
    .window_pos_ready (pos_ready[0]),
    .window_pos_eot   (pos_eot[0]),
    .window_pos_scale (pos_scale[0]),
    .window_pos_x     (pos_x[0]),
    .window_pos_y     (pos_y[0]),
    .busy             (busy[0])
  );

  window_pos_gen #(
    .X_STEP (4),
    .Y_STEP (4)
  ) u_dut1 (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid[1]),
    .cmd_ready        (cmd_ready[1]),
    .cmd_scale        (cmd_scale[1]),
    .cmd_width        (cmd_width[1]),
    .cmd_height       (cmd_height[1]),
    .cmd_last         (cmd_last[1]),
    .window_pos_valid (pos_valid[1]),
    .window_pos_ready (pos_ready[1]),
    .window_pos_eot   (pos_eot[1]),
    .window_pos_scale (pos_scale[1]),
    .window_pos_x     (pos_x[1]),
    .window_pos_y     (pos_y[1]),
    .busy             (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one command to instance sel and follow the whole scan, comparing every cycle
  // (stalled ones included) with the expected origin list.
  task automatic run_cmd(input int sel, input int w, input int h, input int sc,
                         input bit lst, input int rdy_pct);
    int xs[$];
    int ys[$];
    int st;
    int n;
    int i;
    int cyc;
    st = (sel == 0) ? 1 : 4;
    if (w < WIN || h < WIN) begin
      if (lst) begin
        xs.push_back(0);
        ys.push_back(0);
      end
    end else begin
      for (int y = 0; y <= h - WIN; y += st) begin
        for (int x = 0; x <= w - WIN; x += st) begin
          xs.push_back(x);
          ys.push_back(y);
        end
      end
    end
    n = xs.size();

    @(negedge clk);
    check("cmd_ready_before", cmd_ready[sel], 1);
    cmd_valid[sel]  = 1'b1;
    cmd_scale[sel]  = 8'(sc);
    cmd_width[sel]  = 7'(w);
    cmd_height[sel] = 7'(h);
    cmd_last[sel]   = lst;
    @(negedge clk);
    cmd_valid[sel] = 1'b0;

    i   = 0;
    cyc = 0;
    while (i < n) begin
      check("valid_during_scan", pos_valid[sel], 1);
      if (pos_valid[sel] !== 1'b1) break;
      check("x", pos_x[sel], xs[i]);
      check("y", pos_y[sel], ys[i]);
      check("scale", pos_scale[sel], sc & 8'hff);
      check("eot", pos_eot[sel], (lst && i == n - 1) ? 1 : 0);
      check("busy_scan", busy[sel], 1);
      check("cmd_ready_scan", cmd_ready[sel], 0);
      pos_ready[sel] = ($urandom_range(99) < rdy_pct);
      if (pos_ready[sel]) i++;
      cyc++;
      if (cyc > 5000) begin
        check("scan_cycle_budget", cyc, 0);
        break;
      end
      @(negedge clk);
    end
    pos_ready[sel] = 1'b0;
    check("valid_after", pos_valid[sel], 0);
    check("cmd_ready_after", cmd_ready[sel], 1);
    check("busy_after", busy[sel], 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k]  = 1'b0;
      cmd_scale[k]  = '0;
      cmd_width[k]  = '0;
      cmd_height[k] = '0;
      cmd_last[k]   = 1'b0;
      pos_ready[k]  = 1'b0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    #11;
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", pos_valid[k], 0);
      check("rst_eot", pos_eot[k], 0);
      check("rst_x", pos_x[k], 0);
      check("rst_y", pos_y[k], 0);
      check("rst_scale", pos_scale[k], 0);
      check("rst_busy", busy[k], 0);
      check("rst_cmd_ready", cmd_ready[k], 1);
    end
    @(negedge clk);
    rst = 1'b1;

    run_cmd(0, 25, 25, 3, 1'b0, 100);
    run_cmd(0, 45, 45, 0, 1'b1, 100);
    run_cmd(0, 45, 45, 0, 1'b1, 50);
    run_cmd(1, 45, 45, 7, 1'b1, 100);
    run_cmd(1, 45, 45, 7, 1'b1, 50);
    run_cmd(0, 20, 45, 9, 1'b0, 100);
    run_cmd(0, 20, 20, 9, 1'b1, 100);

    for (int r = 0; r < 6; r++) begin
      run_cmd(r % 2, int'($urandom_range(45)), int'($urandom_range(45)),
              int'($urandom_range(255)), 1'($urandom_range(1)), 30 + int'($urandom_range(70)));
    end

    // Asynchronous reset in the middle of a 45x45 scan after 100 accepted beats.
    @(negedge clk);
    cmd_valid[0]  = 1'b1;
    cmd_scale[0]  = 8'd5;
    cmd_width[0]  = 7'd45;
    cmd_height[0] = 7'd45;
    cmd_last[0]   = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    pos_ready[0] = 1'b1;
    repeat (100) @(negedge clk);
    check("pre_rst_x", pos_x[0], 100 % 22);
    check("pre_rst_y", pos_y[0], 100 / 22);
    check("pre_rst_valid", pos_valid[0], 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", pos_valid[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_x", pos_x[0], 0);
    check("midrst_y", pos_y[0], 0);
    check("midrst_eot", pos_eot[0], 0);
    check("midrst_cmd_ready", cmd_ready[0], 1);
    pos_ready[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_cmd(0, 25, 25, 3, 1'b0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
